// File: rtl/conv_pkg.sv
// conv_pkg: shared state encoding, default widths and lane slicing helper for the PE scheduler
package conv_pkg;

  typedef enum logic [2:0] {IDLE, RUN, WAIT_FIN, OUT, DONE} state_e;

  localparam int N_PE_DEF   = 16;
  localparam int ADDR_W_DEF = 20;
  localparam int OFM_W_DEF  = 8;
  localparam int CNT_W_DEF  = 16;

  function automatic int lane_lo(input int lane, input int w);
    return lane * w;
  endfunction

endpackage

// File: rtl/conv_pe_sched_if.sv
// conv_pe_sched_if: packed OFM output handshake between the scheduler and its consumer
interface conv_pe_sched_if
  import conv_pkg::*;
#(
  parameter int N_PE  = N_PE_DEF,
  parameter int OFM_W = OFM_W_DEF
);
  logic                  ofm_valid;
  logic                  ofm_ready;
  logic [N_PE*OFM_W-1:0] ofm_data;
  logic [N_PE-1:0]       ofm_mask;

  modport master (output ofm_valid, ofm_data, ofm_mask, input ofm_ready);
  modport slave  (input ofm_valid, ofm_data, ofm_mask, output ofm_ready);
endinterface

// File: rtl/conv_waddr_gen.sv
// conv_waddr_gen: one lane's weight address register, base + LANE*stride + mac offset, wrapping
module conv_waddr_gen
  import conv_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LANE   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic              inc_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W-1:0] stride_i,
  output logic [ADDR_W-1:0] addr_o
);
  logic [ADDR_W-1:0] addr_q, addr_d;

  // Restart at the lane origin on load, step by one per MAC cycle; all arithmetic wraps
  always_comb addr_d = clr_i ? '0 : load_i ? base_i + ADDR_W'(LANE) * stride_i : inc_i ? addr_q + ADDR_W'(1) : addr_q;

  // Address register
  always_ff @(posedge clk or negedge reset)
    if (!reset) addr_q <= '0;
    else addr_q <= addr_d;

  assign addr_o = addr_q;
endmodule

// File: rtl/conv_pe_sched.sv
// conv_pe_sched: masked multi-pixel sequencer driving PE enables/addresses and collecting OFM results
module conv_pe_sched
  import conv_pkg::*;
#(
  parameter int N_PE   = N_PE_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int OFM_W  = OFM_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [CNT_W-1:0]       cfg_mac_len,
  input  logic [CNT_W-1:0]       cfg_n_out,
  input  logic [N_PE-1:0]        cfg_pe_mask,
  input  logic [ADDR_W-1:0]      cfg_w_base,
  input  logic [ADDR_W-1:0]      cfg_w_stride,
  output logic [N_PE-1:0]        PE_en,
  output logic [N_PE*ADDR_W-1:0] addr_w,
  input  logic [N_PE-1:0]        PE_finish,
  input  logic [N_PE*OFM_W-1:0]  OFM_in,
  output logic                   busy,
  output logic                   done,
  conv_pe_sched_if.master        ofm
);
  state_e                state_q;
  logic [CNT_W-1:0]      mac_cnt_q, out_cnt_q, mac_len_q, n_out_q;
  logic [ADDR_W-1:0]     base_q, stride_q;
  logic [N_PE-1:0]       mask_q, sticky_q, pe_en_q;
  logic [N_PE*OFM_W-1:0] data_q;
  logic                  valid_q, busy_q, done_q;

  logic [N_PE-1:0]   fin_new;
  logic              all_fin, degen, mac_last, last_pix, hs, a_load, a_inc;
  logic [ADDR_W-1:0] a_base, a_stride;

  assign fin_new  = PE_finish & mask_q & ~sticky_q;
  assign all_fin  = ((sticky_q | fin_new) & mask_q) == mask_q;
  assign degen    = cfg_pe_mask == '0 || cfg_n_out == '0 || cfg_mac_len == '0;
  assign mac_last = mac_cnt_q == mac_len_q - CNT_W'(1);
  assign last_pix = out_cnt_q + CNT_W'(1) == n_out_q;
  assign hs       = state_q == OUT && ofm.ofm_ready;
  assign a_load   = !abort && ((state_q == IDLE && start && !degen) || (hs && !last_pix));
  assign a_inc    = !abort && state_q == RUN && !mac_last;
  assign a_base   = state_q == IDLE ? cfg_w_base : base_q;
  assign a_stride = state_q == IDLE ? cfg_w_stride : stride_q;

  for (genvar i = 0; i < N_PE; i++) begin : g_lane
    conv_waddr_gen #(.ADDR_W(ADDR_W), .LANE(i)) u_addr (
      .clk      (clk),
      .reset    (reset),
      .clr_i    (abort),
      .load_i   (a_load),
      .inc_i    (a_inc),
      .base_i   (a_base),
      .stride_i (a_stride),
      .addr_o   (addr_w[i*ADDR_W +: ADDR_W])
    );
  end

  // Job sequencer: latches config, counts MAC cycles and pixels, captures first finish per lane
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q   <= IDLE;
      mac_cnt_q <= '0;
      out_cnt_q <= '0;
      mac_len_q <= '0;
      n_out_q   <= '0;
      base_q    <= '0;
      stride_q  <= '0;
      mask_q    <= '0;
      sticky_q  <= '0;
      pe_en_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else if (abort) begin
      state_q   <= IDLE;
      mac_cnt_q <= '0;
      out_cnt_q <= '0;
      sticky_q  <= '0;
      pe_en_q   <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == RUN || state_q == WAIT_FIN) begin
        sticky_q <= sticky_q | fin_new;
        for (int i = 0; i < N_PE; i++)
          if (fin_new[i]) data_q[lane_lo(i, OFM_W) +: OFM_W] <= OFM_in[lane_lo(i, OFM_W) +: OFM_W];
      end
      case (state_q)
        IDLE:
          if (start) begin
            mac_len_q <= cfg_mac_len;
            n_out_q   <= cfg_n_out;
            base_q    <= cfg_w_base;
            stride_q  <= cfg_w_stride;
            mask_q    <= cfg_pe_mask;
            mac_cnt_q <= '0;
            out_cnt_q <= '0;
            sticky_q  <= '0;
            data_q    <= '0;
            busy_q    <= 1'b1;
            if (degen) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
              pe_en_q <= cfg_pe_mask;
            end
          end
        RUN:
          if (mac_last) begin
            state_q <= WAIT_FIN;
            pe_en_q <= '0;
          end else mac_cnt_q <= mac_cnt_q + CNT_W'(1);
        WAIT_FIN:
          if (all_fin) begin
            state_q <= OUT;
            valid_q <= 1'b1;
          end
        OUT:
          if (ofm.ofm_ready) begin
            out_cnt_q <= out_cnt_q + CNT_W'(1);
            valid_q   <= 1'b0;
            if (last_pix) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= RUN;
              mac_cnt_q <= '0;
              sticky_q  <= '0;
              data_q    <= '0;
              pe_en_q   <= mask_q;
            end
          end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end

  assign PE_en         = pe_en_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign ofm.ofm_valid = valid_q;
  assign ofm.ofm_data  = data_q;
  assign ofm.ofm_mask  = mask_q;
endmodule

// File: tb/tb_conv_pe_sched.sv
// tb_conv_pe_sched: directed jobs with a queue scoreboard checked by an independent output monitor
module tb_conv_pe_sched;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [15:0]  cfg_mac_len = '0;
  logic [15:0]  cfg_n_out = '0;
  logic [15:0]  cfg_pe_mask = '0;
  logic [19:0]  cfg_w_base = '0;
  logic [19:0]  cfg_w_stride = '0;
  logic [15:0]  pe_en;
  logic [319:0] addr_w;
  logic [15:0]  pe_finish = '0;
  logic [127:0] ofm_in = '0;
  logic         busy, done;

  int n_cmp = 0;
  int n_bad = 0;
  logic [127:0] exp_data[$];
  logic [15:0]  exp_mask[$];

  conv_pe_sched_if #(.N_PE(16), .OFM_W(8)) ofm_if ();

  conv_pe_sched #(.N_PE(16), .ADDR_W(20), .OFM_W(8), .CNT_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .cfg_mac_len  (cfg_mac_len),
    .cfg_n_out    (cfg_n_out),
    .cfg_pe_mask  (cfg_pe_mask),
    .cfg_w_base   (cfg_w_base),
    .cfg_w_stride (cfg_w_stride),
    .PE_en        (pe_en),
    .addr_w       (addr_w),
    .PE_finish    (pe_finish),
    .OFM_in       (ofm_in),
    .busy         (busy),
    .done         (done),
    .ofm          (ofm_if)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [19:0] lane_addr(input int i);
    return addr_w[i*20 +: 20];
  endfunction

  // Monitor: any accepted output word must match the oldest expected word
  always @(negedge clk)
    if (reset && ofm_if.ofm_valid && ofm_if.ofm_ready) begin
      if (exp_data.size() == 0) chk("sb_unexpected_word", 1, 0);
      else begin
        chk("sb_ofm_data", ofm_if.ofm_data, exp_data.pop_front());
        chk("sb_ofm_mask", ofm_if.ofm_mask, exp_mask.pop_front());
      end
    end

  task automatic start_job(input logic [15:0] m, input logic [15:0] mac, input logic [15:0] n,
                           input logic [19:0] b, input logic [19:0] s);
    cfg_pe_mask = m; cfg_mac_len = mac; cfg_n_out = n; cfg_w_base = b; cfg_w_stride = s;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int k = 0;
    while (!ofm_if.ofm_valid && k < 40) begin
      tick();
      k++;
    end
    chk(nm, ofm_if.ofm_valid, 1);
  endtask

  task automatic finish_job(input string nm);
    ofm_if.ofm_ready = 1'b1;
    tick();
    ofm_if.ofm_ready = 1'b0;
    chk({nm, "_done"}, done, 1);
    chk({nm, "_busy_in_done"}, busy, 1);
    tick();
    chk({nm, "_done_pulse"}, done, 0);
    chk({nm, "_busy_low"}, busy, 0);
  endtask

  initial begin
    logic [127:0] ed;
    logic [19:0]  wrap_tab [4] = '{20'hFFFFE, 20'hFFFFF, 20'h00000, 20'h00001};
    int n;
    int k;
    logic bad;
    ofm_if.ofm_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("rst_pe_en", pe_en, 0);
    chk("rst_addr_w", addr_w, 0);
    chk("rst_valid", ofm_if.ofm_valid, 0);
    chk("rst_data", ofm_if.ofm_data, 0);
    chk("rst_mask", ofm_if.ofm_mask, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    tick();
    reset = 1'b1;
    tick();

    // Basic job: full mask, 9 MAC cycles, lane i result i+1
    ed = '0;
    for (int i = 0; i < 16; i++) ed[i*8 +: 8] = 8'(i + 1);
    exp_data.push_back(ed); exp_mask.push_back(16'hFFFF);
    start_job(16'hFFFF, 16'd9, 16'd1, 20'h100, 20'h10);
    chk("basic_busy_rise", busy, 1);
    n = 0;
    for (int c = 0; c < 12; c++) begin
      if (pe_en != 0) begin
        chk("basic_pe_en_val", pe_en, 16'hFFFF);
        chk("basic_lane3_addr", lane_addr(3), 20'h130 + 20'(n));
        n++;
      end
      if (c == 2) begin pe_finish = 16'hFFFF; ofm_in = ed; end
      if (c == 3) pe_finish = '0;
      tick();
    end
    chk("basic_pe_en_cycles", n, 9);
    wait_valid("basic_valid");
    finish_job("basic");

    // Mask 00F0 with stray lane-0 finish, two pixels back to back
    start_job(16'h00F0, 16'd3, 16'd2, 20'h0, 20'h1);
    for (int p = 0; p < 2; p++) begin
      ofm_in = {16{8'hEE}};
      ofm_in[7:0] = 8'hAA;
      pe_finish = 16'h0001;
      tick();
      pe_finish = '0;
      k = 0;
      while (pe_en != 0 && k < 20) begin tick(); k++; end
      chk("mask_pe_en_fall", pe_en, 0);
      ed = '0;
      for (int i = 4; i < 8; i++) begin
        ed[i*8 +: 8] = 8'(8'h40 + p*16 + i);
        ofm_in[i*8 +: 8] = 8'(8'h40 + p*16 + i);
      end
      exp_data.push_back(ed); exp_mask.push_back(16'h00F0);
      pe_finish = 16'h00F0;
      tick();
      pe_finish = '0;
      chk("mask_finish_to_valid", ofm_if.ofm_valid, 1);
      if (p == 0) begin
        ofm_if.ofm_ready = 1'b1;
        tick();
        ofm_if.ofm_ready = 1'b0;
        chk("mask_b2b_pe_en", pe_en, 16'h00F0);
        chk("mask_b2b_lane4_addr", lane_addr(4), 20'h4);
        chk("mask_b2b_no_done", done, 0);
      end else finish_job("mask");
    end

    // Backpressure: lane 1 finishes twice with a new value; first capture must stick
    ed = '0;
    ed[31:0] = 32'h44332211;
    exp_data.push_back(ed); exp_mask.push_back(16'h000F);
    start_job(16'h000F, 16'd2, 16'd1, 20'h0, 20'h1);
    ofm_in = ed;
    pe_finish = 16'h000F;
    tick();
    ofm_in[15:8] = 8'h99;
    pe_finish = 16'h0002;
    wait_valid("bp_valid");
    for (int s = 0; s < 5; s++) begin
      chk("bp_data_stable", ofm_if.ofm_data, ed);
      chk("bp_no_pe_en", pe_en, 0);
      tick();
    end
    pe_finish = '0;
    finish_job("bp");

    // Address wrap at 2^20
    exp_data.push_back(128'h5A); exp_mask.push_back(16'h0001);
    start_job(16'h0001, 16'd4, 16'd1, 20'hFFFFE, 20'h0);
    for (int c = 0; c < 4; c++) begin
      chk("wrap_lane0_addr", lane_addr(0), wrap_tab[c]);
      tick();
    end
    ofm_in = 128'h5A;
    pe_finish = 16'h0001;
    wait_valid("wrap_valid");
    pe_finish = '0;
    finish_job("wrap");

    // Abort in RUN
    start_job(16'hFFFF, 16'd9, 16'd1, 20'h0, 20'h1);
    tick(); tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_pe_en", pe_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_valid", ofm_if.ofm_valid, 0);
    bad = 1'b0;
    for (int c = 0; c < 12; c++) begin
      bad |= done | (pe_en != 0);
      tick();
    end
    chk("abort_no_done", bad, 0);

    // Asynchronous reset while waiting for finishes
    start_job(16'h0003, 16'd2, 16'd1, 20'h0, 20'h1);
    tick(); tick(); tick();
    chk("wf_busy", busy, 1);
    chk("wf_mask", ofm_if.ofm_mask, 16'h0003);
    #1 reset = 1'b0;
    #1;
    chk("arst_pe_en", pe_en, 0);
    chk("arst_addr_w", addr_w, 0);
    chk("arst_valid", ofm_if.ofm_valid, 0);
    chk("arst_mask", ofm_if.ofm_mask, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    #1 reset = 1'b1;
    tick();

    // Normal job after reset
    ed = '0;
    ed[71:64] = 8'h77;
    exp_data.push_back(ed); exp_mask.push_back(16'h0100);
    start_job(16'h0100, 16'd1, 16'd1, 20'h10, 20'h2);
    chk("post_pe_en", pe_en, 16'h0100);
    chk("post_lane8_addr", lane_addr(8), 20'h20);
    ofm_in = ed;
    pe_finish = 16'h0100;
    wait_valid("post_valid");
    pe_finish = '0;
    finish_job("post");

    // Degenerate config: zero MAC length
    start_job(16'hFFFF, 16'd0, 16'd1, 20'h0, 20'h1);
    chk("degen_done", done, 1);
    chk("degen_pe_en", pe_en, 0);
    tick();
    chk("degen_done_pulse", done, 0);
    chk("degen_busy_low", busy, 0);
    chk("degen_pe_en_after", pe_en, 0);

    // Start while busy is ignored; config changes have no effect mid-job
    ed = '0;
    ed[31:0] = 32'hD4C3B2A1;
    exp_data.push_back(ed); exp_mask.push_back(16'h000F);
    start_job(16'h000F, 16'd4, 16'd1, 20'h0, 20'h1);
    n = (pe_en != 0) ? 1 : 0;
    cfg_mac_len = 16'd1; cfg_pe_mask = 16'hFFFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (pe_en != 0) n++;
      if (pe_en != 0 && pe_en != 16'h000F) bad = 1'b1;
      if (c == 0) begin ofm_in = ed; pe_finish = 16'h000F; end
      if (c == 1) pe_finish = '0;
      tick();
    end
    chk("busy_start_pe_cycles", n, 4);
    chk("busy_start_pe_mask", bad, 0);
    wait_valid("busy_start_valid");
    finish_job("busy_start");

    tick(); tick();
    chk("sb_all_consumed", exp_data.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
